// File: rtl/monitor_event_logger.sv
// rtl/monitor_event_logger.sv - monitor_valid edge timestamp logger with FIFO and APB register slave (optional MONITOR_LOGGER_WATERMARK_EN)
module monitor_event_logger #(
  parameter int DEPTH          = 16,
  parameter int TS_WIDTH       = 32,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      monitor_valid_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      event_irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic                ctrl_en;
  logic                ctrl_irq_en;
  logic                clr_pend;
  logic                mv_q;
  logic                overflow;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       level;
  logic [LW-1:0]       level_next;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [31:0]         evt_cnt;
  logic [31:0]         drop_cnt;
  logic [TS_WIDTH-1:0] mem [DEPTH];

  logic                access;
  logic                wr_acc;
  logic                rd_acc;
  logic [2:0]          offset;
  logic                empty;
  logic                full;
  logic                evt;
  logic                pop;
  logic                push;
  logic                drop;
  logic [31:0]         ts_ext;
  logic [31:0]         status;
  logic [8:0]          level_9;
  logic                irq_next;
  logic                unused_bits;

`ifdef MONITOR_LOGGER_WATERMARK_EN
  logic [8:0]          wmark;
  logic [8:0]          wmark_eff;
`endif

  assign PREADY      = 1'b1;
  assign access      = PSEL & PENABLE;
  assign wr_acc      = access & PWRITE;
  assign rd_acc      = access & ~PWRITE;
  assign offset      = PADDR[4:2];
  assign empty       = (level == '0);
  assign full        = (level == LW'(DEPTH));
  // A CLR cycle swallows any edge seen in it so the flushed FIFO stays empty.
  assign evt         = monitor_valid_i & ~mv_q & ctrl_en & ~clr_pend;
  assign pop         = rd_acc & (offset == 3'd2) & ~empty;
  assign push        = evt & (~full | pop);
  assign drop        = evt & full & ~pop;
  assign unused_bits = ^{PADDR, PWDATA};

  // Zero-extend the head entry, level and status fields to the 32-bit bus.
  always_comb begin
    ts_ext             = '0;
    ts_ext[TS_WIDTH-1:0] = mem[rd_ptr];
    level_9            = '0;
    level_9[LW-1:0]    = level_next;
    status             = '0;
    status[LW-1:0]     = level;
    status[16]         = empty;
    status[17]         = full;
    status[18]         = overflow;
  end

  // FIFO occupancy after this cycle's push/pop (or flush).
  always_comb begin
    level_next = level;
    if (clr_pend) begin
      level_next = '0;
    end else if (push && !pop) begin
      level_next = level + LW'(1);
    end else if (pop && !push) begin
      level_next = level - LW'(1);
    end
  end

`ifdef MONITOR_LOGGER_WATERMARK_EN
  // A programmed watermark of zero behaves like one.
  always_comb begin
    wmark_eff = (wmark == '0) ? 9'd1 : wmark;
    irq_next  = ctrl_irq_en & (level_9 >= wmark_eff);
  end
`else
  // Interrupt whenever anything is queued.
  always_comb begin
    irq_next = ctrl_irq_en & (level_9 != '0);
  end
`endif

  // Zero-wait-state APB read mux and error decode during the access phase.
  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (rd_acc) begin
      case (offset)
        3'd0: PRDATA = {30'd0, ctrl_irq_en, ctrl_en};
        3'd1: PRDATA = status;
        3'd2: begin
          if (empty) PSLVERR = 1'b1;
          else       PRDATA  = ts_ext;
        end
        3'd3: PRDATA = evt_cnt;
        3'd4: PRDATA = drop_cnt;
`ifdef MONITOR_LOGGER_WATERMARK_EN
        3'd5: PRDATA = {23'd0, wmark};
`endif
        default: PSLVERR = 1'b1;
      endcase
    end else if (wr_acc) begin
      case (offset)
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4: PSLVERR = 1'b0;
`ifdef MONITOR_LOGGER_WATERMARK_EN
        3'd5: PSLVERR = 1'b0;
`endif
        default: PSLVERR = 1'b1;
      endcase
    end
  end

  // Control register; CLR is a one-cycle pulse acted on in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      clr_pend    <= 1'b0;
    end else if (wr_acc && offset == 3'd0) begin
      ctrl_en     <= PWDATA[0];
      ctrl_irq_en <= PWDATA[1];
      clr_pend    <= PWDATA[2];
    end else begin
      clr_pend    <= 1'b0;
    end
  end

`ifdef MONITOR_LOGGER_WATERMARK_EN
  // Watermark threshold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wmark <= 9'd1;
    end else if (wr_acc && offset == 3'd5) begin
      wmark <= PWDATA[8:0];
    end
  end
`endif

  // Edge detector history and free-running timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_q   <= 1'b0;
      ts_cnt <= '0;
    end else begin
      mv_q <= monitor_valid_i;
      if (clr_pend)     ts_cnt <= '0;
      else if (ctrl_en) ts_cnt <= ts_cnt + TS_WIDTH'(1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      level <= level_next;
      if (clr_pend) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ts_cnt;
  end

  // Saturating statistics and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clr_pend) begin
      evt_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && evt_cnt != '1)  evt_cnt  <= evt_cnt + 32'd1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
      if (drop) begin
        overflow <= 1'b1;
      end else if (wr_acc && offset == 3'd1 && PWDATA[18]) begin
        overflow <= 1'b0;
      end
    end
  end

  // Registered level interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) event_irq_o <= 1'b0;
    else        event_irq_o <= irq_next;
  end

endmodule
